// File: rtl/mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mul_pipe
// Purpose  : STAGES-deep integer multiply pipeline carrying result, zero,
//            overflow and destination tag, with in-flight hazard lookup.
//            Optional feature macro: MUL_UNSIGNED_EN (adds in_unsigned).
// Revision : 1.0
// ============================================================================
module mul_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [4:0]       in_dst,
`ifdef MUL_UNSIGNED_EN
  input  logic             in_unsigned,
`endif
  input  logic             stall,
  input  logic             flush,
  input  logic [4:0]       query_reg,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic [4:0]       dst,
  output logic             busy,
  output logic             query_hit
);

  localparam int c_PROD_W = 2 * WIDTH;

  logic                c_unused_guard;
  logic                w_uns;
  logic [c_PROD_W-1:0] w_a_ext;
  logic [c_PROD_W-1:0] w_b_ext;
  logic [c_PROD_W-1:0] w_prod;
  logic [WIDTH-1:0]    w_result;
  logic                w_zero;
  logic                w_ovf;

  assign c_unused_guard = 1'b0;

`ifdef MUL_UNSIGNED_EN
  assign w_uns = in_unsigned;
`else
  assign w_uns = c_unused_guard;
`endif

  // Operands are extended to full product width so a single truncated
  // multiply yields the exact 2*WIDTH-bit product for either signedness.
  always_comb begin
    w_a_ext = w_uns ? {{WIDTH{1'b0}}, in_a} : {{WIDTH{in_a[WIDTH-1]}}, in_a};
    w_b_ext = w_uns ? {{WIDTH{1'b0}}, in_b} : {{WIDTH{in_b[WIDTH-1]}}, in_b};
    w_prod  = w_a_ext * w_b_ext;
  end

  assign w_result = w_prod[WIDTH-1:0];
  assign w_zero   = (w_result == '0);
  assign w_ovf    = w_uns ? (|w_prod[c_PROD_W-1:WIDTH])
                          : (w_prod[c_PROD_W-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}});

  // Index 0 is the first stage, index STAGES-1 drives the outputs.
  logic [STAGES-1:0]            r_valid;
  logic [STAGES-1:0][WIDTH-1:0] r_result;
  logic [STAGES-1:0]            r_zero;
  logic [STAGES-1:0]            r_ovf;
  logic [STAGES-1:0][4:0]       r_dst;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid  <= '0;
      r_result <= '0;
      r_zero   <= '0;
      r_ovf    <= '0;
      r_dst    <= '0;
    end else if (flush) begin
      r_valid <= '0;
    end else if (!stall) begin
      r_valid  <= {r_valid[STAGES-2:0], in_valid};
      r_result <= {r_result[STAGES-2:0], w_result};
      r_zero   <= {r_zero[STAGES-2:0], w_zero};
      r_ovf    <= {r_ovf[STAGES-2:0], w_ovf};
      r_dst    <= {r_dst[STAGES-2:0], in_dst};
    end
  end

  assign out_valid = r_valid[STAGES-1];
  assign result    = out_valid ? r_result[STAGES-1] : '0;
  assign zero      = out_valid & r_zero[STAGES-1];
  assign overflow  = out_valid & r_ovf[STAGES-1];
  assign dst       = out_valid ? r_dst[STAGES-1] : 5'd0;
  assign busy      = |r_valid;

  // Register 0 is never a real hazard, so it is excluded from the lookup.
  logic [STAGES-1:0] w_match;

  for (genvar i = 0; i < STAGES; i++) begin : g_hit
    assign w_match[i] = r_valid[i] & (r_dst[i] == query_reg);
  end

  assign query_hit = (query_reg != 5'd0) & (|w_match);

endmodule
`default_nettype wire

// File: tb/tb_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_pipe
// Purpose  : Self-checking bench for mul_pipe against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_mul_pipe;

  localparam int WIDTH  = 32;
  localparam int STAGES = 5;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [WIDTH-1:0]  in_a = '0;
  logic [WIDTH-1:0]  in_b = '0;
  logic [4:0]        in_dst = '0;
  logic              in_unsigned = 1'b0;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  logic [4:0]        query_reg = '0;
  logic              out_valid;
  logic [WIDTH-1:0]  result;
  logic              zero;
  logic              overflow;
  logic [4:0]        dst;
  logic              busy;
  logic              query_hit;

  int errors = 0;
  int checks = 0;

  mul_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_dst     (in_dst),
`ifdef MUL_UNSIGNED_EN
    .in_unsigned(in_unsigned),
`endif
    .stall      (stall),
    .flush      (flush),
    .query_reg  (query_reg),
    .out_valid  (out_valid),
    .result     (result),
    .zero       (zero),
    .overflow   (overflow),
    .dst        (dst),
    .busy       (busy),
    .query_hit  (query_hit)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of in-flight ops, each aging by one per
  // unstalled edge; the oldest one is visible once its age reaches STAGES.
  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ov;
    logic [4:0]  dst;
    int          age;
  } op_t;

  op_t q[$];

  function automatic bit eff_unsigned();
`ifdef MUL_UNSIGNED_EN
    return in_unsigned;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b, input bit uns,
                                  output logic [31:0] res, output logic ov);
    longint      sp;
    logic [63:0] up;
    longint      lim_hi;
    longint      lim_lo;
    lim_hi = 64'sd2147483647;
    lim_lo = -64'sd2147483648;
    if (uns) begin
      up  = {32'd0, a} * {32'd0, b};
      res = up[31:0];
      ov  = (up > 64'h0000_0000_FFFF_FFFF);
    end else begin
      sp  = longint'(signed'(a)) * longint'(signed'(b));
      res = sp[31:0];
      ov  = (sp > lim_hi) || (sp < lim_lo);
    end
  endfunction

  function automatic void model_edge();
    op_t n;
    if (!reset_n || flush) begin
      q.delete();
      return;
    end
    if (stall) return;
    if (q.size() > 0 && q[0].age == STAGES) void'(q.pop_front());
    foreach (q[i]) q[i].age = q[i].age + 1;
    if (in_valid) begin
      ref_mul(in_a, in_b, eff_unsigned(), n.res, n.ov);
      n.z   = (n.res == 32'd0);
      n.dst = in_dst;
      n.age = 1;
      q.push_back(n);
    end
  endfunction

  function automatic bit m_valid();
    return (q.size() > 0) && (q[0].age == STAGES);
  endfunction

  function automatic bit m_hit();
    if (query_reg == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i].dst == query_reg) return 1'b1;
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    checks++;
    if ({out_valid, busy, query_hit, result, zero, overflow, dst} !== '0) begin
      errors++;
      $display("FAIL reset_state: got v=%0b busy=%0b hit=%0b res=%0h z=%0b ov=%0b dst=%0d, expected all 0",
               out_valid, busy, query_hit, result, zero, overflow, dst);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release: got v=%0b busy=%0b, expected 0 0", out_valid, busy);
    end
  endtask

  task automatic test_latency();
    in_valid = 1'b1; in_a = 32'd3; in_b = 32'd4; in_dst = 5'd9;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      checks++;
      if (c == STAGES) begin
        if ({out_valid, result, zero, overflow, dst} !== {1'b1, 32'd12, 1'b0, 1'b0, 5'd9}) begin
          errors++;
          $display("FAIL latency_out: cycle %0d got v=%0b res=%0d z=%0b ov=%0b dst=%0d, expected 1 12 0 0 9",
                   c, out_valid, result, zero, overflow, dst);
        end
      end else if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL latency_idle: cycle %0d got out_valid=%0b, expected 0", c, out_valid);
      end
      if (c < 6) tick();
    end
    idle(2);
  endtask

  task automatic test_flags();
`ifdef MUL_UNSIGNED_EN
    localparam int N = 4;
`else
    localparam int N = 3;
`endif
    logic [31:0] fa [4] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF};
    logic [31:0] fb [4] = '{32'd2,         32'hFFFF_FFFF, 32'd0, 32'd2};
    logic        fu [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] er [4] = '{32'hFFFF_FFFE, 32'd1, 32'd0, 32'hFFFF_FFFE};
    logic        ez [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic        eo [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int k;
    for (int c = 0; c < N + STAGES; c++) begin
      in_valid = (c < N);
      if (c < N) begin
        in_a = fa[c]; in_b = fb[c]; in_unsigned = fu[c]; in_dst = 5'(10 + c);
      end
      tick();
      k = c + 1 - STAGES;
      if (k >= 0 && k < N) begin
        checks++;
        if ({out_valid, result, zero, overflow, dst} !== {1'b1, er[k], ez[k], eo[k], 5'(10 + k)}) begin
          errors++;
          $display("FAIL flags_op%0d: got v=%0b res=%0h z=%0b ov=%0b dst=%0d, expected 1 %0h %0b %0b %0d",
                   k, out_valid, result, zero, overflow, dst, er[k], ez[k], eo[k], 10 + k);
        end
      end
    end
    in_unsigned = 1'b0;
    idle(2);
  endtask

  task automatic test_stall();
    int  idx = 0;
    bit  ev;
    for (int c = 0; c < 14; c++) begin
      stall    = (c == 3 || c == 4);
      in_valid = (idx < 5);
      in_dst   = 5'(idx + 1);
      in_a     = 32'(idx + 1);
      in_b     = 32'd3;
      tick();
      if (in_valid && !stall) idx++;
      ev = (c + 1 >= 7) && (c + 1 <= 11);
      checks++;
      if ({out_valid, dst, result} !== {ev, ev ? 5'(c - 5) : 5'd0, ev ? 32'((c - 5) * 3) : 32'd0}) begin
        errors++;
        $display("FAIL stall_order: cycle %0d got v=%0b dst=%0d res=%0d, expected v=%0b dst=%0d",
                 c + 1, out_valid, dst, result, ev, ev ? c - 5 : 0);
      end
    end
    stall = 1'b0;
    idle(2);
    // Freeze the pipeline while a result sits in the output stage.
    in_valid = 1'b1; in_a = 32'd2; in_b = 32'd2; in_dst = 5'd3;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < STAGES - 1; i++) tick();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({out_valid, dst, result} !== {1'b1, 5'd3, 32'd4}) begin
        errors++;
        $display("FAIL stall_hold: stall cycle %0d got v=%0b dst=%0d res=%0d, expected 1 3 4",
                 i, out_valid, dst, result);
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: got out_valid=%0b, expected 0", out_valid);
    end
    idle(2);
  endtask

  task automatic test_flush();
    bit seen = 1'b0;
    in_valid = 1'b1; in_a = 32'd7; in_b = 32'd7;
    for (int i = 0; i < 3; i++) begin
      in_dst = 5'(20 + i);
      tick();
    end
    stall = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL flush_busy: got busy=%0b v=%0b, expected 0 0", busy, out_valid);
    end
    for (int i = 0; i < STAGES + 3; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL flush_leak: got out_valid=1 after flush, expected never");
    end
  endtask

  task automatic test_reset_midstream();
    bit seen = 1'b0;
    in_valid = 1'b1; in_a = 32'd9; in_b = 32'd9;
    for (int i = 0; i < 3; i++) begin
      in_dst = 5'(4 + i);
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: got busy=%0b, expected 1", busy);
    end
    query_reg = 5'd5;
    reset_n   = 1'b0;
    q.delete();
    #1;
    checks++;
    if ({out_valid, busy, query_hit, result, zero, overflow, dst} !== '0) begin
      errors++;
      $display("FAIL rst_mid_async: got v=%0b busy=%0b hit=%0b res=%0h dst=%0d, expected all 0",
               out_valid, busy, query_hit, result, dst);
    end
    tick(); tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_busy: got busy=%0b, expected 0", busy);
    end
    for (int i = 0; i < STAGES + 3; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rst_mid_leak: got out_valid=1 after reset, expected never");
    end
    query_reg = 5'd0;
  endtask

  task automatic test_hazard();
    bit seen = 1'b0;
    query_reg = 5'd7;
    in_valid = 1'b1; in_a = 32'd1; in_b = 32'd1; in_dst = 5'd7;
    #1;
    checks++;
    if (query_hit !== 1'b0) begin
      errors++;
      $display("FAIL hazard_same_cycle: got query_hit=%0b, expected 0", query_hit);
    end
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      checks++;
      if (query_hit !== (c <= STAGES)) begin
        errors++;
        $display("FAIL hazard_window: cycle %0d got query_hit=%0b, expected %0b", c, query_hit, c <= STAGES);
      end
      if (c < 6) tick();
    end
    query_reg = 5'd0;
    in_valid = 1'b1; in_dst = 5'd0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < STAGES + 1; i++) begin
      if (query_hit) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL hazard_reg0: got query_hit=1 for register 0, expected never");
    end
  endtask

  task automatic test_random();
    bit          ev;
    logic [31:0] eres;
    for (int c = 0; c < 400; c++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_a        = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : 32'($urandom);
      in_b        = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : 32'($urandom);
      in_dst      = 5'($urandom_range(0, 7));
      in_unsigned = 1'($urandom_range(0, 1));
      stall       = ($urandom_range(0, 5) == 0);
      flush       = ($urandom_range(0, 40) == 0);
      query_reg   = 5'($urandom_range(0, 7));
      tick();
      ev   = m_valid();
      eres = ev ? q[0].res : 32'd0;
      checks++;
      if ({out_valid, result} !== {ev, eres}) begin
        errors++;
        $display("FAIL rand_result: cycle %0d got v=%0b res=%0h, expected v=%0b res=%0h",
                 c, out_valid, result, ev, eres);
      end
      checks++;
      if ({zero, overflow, dst} !== {ev && q[0].z, ev && q[0].ov, ev ? q[0].dst : 5'd0}) begin
        errors++;
        $display("FAIL rand_flags: cycle %0d got z=%0b ov=%0b dst=%0d, expected z=%0b ov=%0b dst=%0d",
                 c, zero, overflow, dst, ev && q[0].z, ev && q[0].ov, ev ? q[0].dst : 5'd0);
      end
      checks++;
      if ({busy, query_hit} !== {q.size() != 0, m_hit()}) begin
        errors++;
        $display("FAIL rand_status: cycle %0d got busy=%0b hit=%0b, expected busy=%0b hit=%0b",
                 c, busy, query_hit, q.size() != 0, m_hit());
      end
    end
    in_unsigned = 1'b0;
    query_reg   = 5'd0;
    idle(STAGES + 2);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_flags();
    test_stall();
    test_flush();
    test_reset_midstream();
    test_hazard();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul_pipe.md
# mul_pipe

Parametrised multi-cycle integer multiply pipeline for the execute stage. It takes over from the fixed five-stage M-chain, whose last stage only forwarded result, zero, overflow and dst. It accepts one operation per cycle and carries each result with its destination tag through `STAGES` register stages. Writeback sees result, flags and dst with a valid bit, and decode gets a hazard lookup over all in-flight destinations.

## Interface
Parameters:
- `WIDTH`, default `REG_SIZE` (32): operand and result width.
- `STAGES`, default 5: pipeline depth and latency in cycles; legal range 2..16.

Ports:
- `clk`  in  1  clock; all registers update on the rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operation present this cycle.
- `in_a`, `in_b`  in  WIDTH  operands.
- `in_dst`  in  5  destination register number.
- `in_unsigned`  in  1  present only with `MUL_UNSIGNED_EN`.
- `stall`  in  1  freezes every stage.
- `flush`  in  1  kills every in-flight operation.
- `query_reg`  in  5  register number to check for a pending write.
- `out_valid`  out  1  last stage holds a live result.
- `result`  out  WIDTH  low WIDTH bits of the product.
- `zero`  out  1  `result == 0`.
- `overflow`  out  1  product does not fit in WIDTH bits.
- `dst`  out  5  destination of the result.
- `busy`  out  1  OR of all stage valid bits.
- `query_hit`  out  1  some valid stage has `dst == query_reg` and `query_reg != 0`.

## Operation
- Full product (2·WIDTH bits) is computed from `in_a`/`in_b` at the input. The low WIDTH bits, zero, overflow and dst are captured into stage 1, then shifted one stage per unstalled edge.
- Signed overflow: the full product is not equal to the sign-extension of its low half.
- Each stage holds: valid, result, zero, overflow, dst.
- The last stage drives the outputs. When it is invalid, `result`, `zero`, `overflow` and `dst` read 0.
- Accept condition: `in_valid & ~stall & ~flush` at a rising edge. If `in_valid` is high while `stall` is high, the op is not taken and upstream must hold it.
- `stall` = 1, `flush` = 0: every stage, including the output stage, holds its contents. `out_valid` and the data stay unchanged.
- `flush` = 1: every valid bit clears at the next edge. `flush` wins over `stall`, and an op presented in the same cycle is dropped. Data fields need not clear, but outputs still read 0 through the valid gating.
- An unstalled edge with no accepted op inserts a bubble (valid = 0) into stage 1.
- `query_hit` and `busy` are combinational from the stage registers only, with no input-to-output path. `in_dst == query_reg` in the same cycle does not hit.
- Reset, asynchronous and valid at any time, including mid-operation: all valid bits and all data registers go to 0 immediately. All outputs read 0 while `reset_n` = 0.

## Timing
- Latency = `STAGES`: an op accepted in cycle 0 drives `out_valid` = 1 in cycle `STAGES` if no stall occurs. Each stall cycle adds one.
- Throughput: one op per cycle with no structural gaps.
- Without a stall, `out_valid` is high for exactly one cycle per op. During a stall it stays high until the next unstalled edge.
- Ops leave in acceptance order; none is duplicated or lost except by `flush` or reset.
- `busy` falls in the cycle after the last valid stage drains or is flushed.
- Reset values: `out_valid`, `busy` and `query_hit` are 0; `result`, `zero`, `overflow` and `dst` are 0.

## Configuration
- `MUL_UNSIGNED_EN` defined: `in_unsigned` exists and is captured per op.
  - `in_unsigned` = 1: the product is unsigned, and overflow = upper WIDTH bits of the product are non-zero.
  - `in_unsigned` = 0: signed, as above.
- Undefined: the port is absent and every op is signed.

## Test plan
All scenarios use WIDTH = 32, STAGES = 5.
- Reset: pull `reset_n` low mid-stream with 3 ops in flight -> all outputs 0 at once; after release `busy` = 0 and nothing emerges.
- Latency: present 3 × 4, dst = 9, in cycle 0 -> cycle 5 shows `out_valid` = 1, `result` = 12, `zero` = 0, `overflow` = 0, `dst` = 9; cycle 6 shows `out_valid` = 0.
- Flags:
  - 0x7FFFFFFF × 2 -> 0xFFFFFFFE with overflow = 1.
  - 0xFFFFFFFF × 0xFFFFFFFF signed -> 1, overflow = 0.
  - 5 × 0 -> zero = 1.
  - With `MUL_UNSIGNED_EN`, 0xFFFFFFFF × 2 unsigned -> 0xFFFFFFFE, overflow = 1.
- Stall: 5 back-to-back ops with dst 1..5; assert `stall` for 2 cycles starting in cycle 3 -> results appear in order 1..5 starting at cycle 7; each appears exactly once without a stall; the output is held during stall cycles; the held op is not re-accepted.
- Flush: 3 ops in flight plus `in_valid` = 1 and `stall` = 1 in the flush cycle -> no `out_valid` ever appears and `busy` = 0 in the next cycle.
- Hazard: op with dst = 7 accepted in cycle 0 -> `query_reg` = 7 gives `query_hit` = 1 in cycles 1..5 and 0 in cycle 6; an op with dst = 0 never hits for `query_reg` = 0.
